// File: rtl/sprite_row_fetcher.sv
// Sole master of the sprite ROM: prefetches the next scanline's row for fireboy and
// icegirl at the start of horizontal blank, then serves the merged sprite pixel.
module sprite_row_fetcher #(
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int ROM_AW   = 11,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        fb_x,
  input  logic [9:0]        fb_y,
  input  logic [9:0]        ig_x,
  input  logic [9:0]        ig_y,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              is_fireboy,
  output logic [7:0]        fireboy_data,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam int                COL_W     = $clog2(SPR_W);
  localparam int                ROW_W     = $clog2(SPR_H);
  localparam logic [COL_W:0]    LAST_COL  = (COL_W+1)'(SPR_W);
  localparam logic [9:0]        BLANK_X   = 10'(H_ACTIVE);
  localparam logic [9:0]        LAST_Y    = 10'(V_TOTAL - 1);
  localparam logic [ROM_AW-1:0] SPR_WORDS = ROM_AW'(SPR_W * SPR_H);

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

  state_t           state, state_next;
  logic             blank_q, blank_prev, trig;
  logic [9:0]       next_y;
  logic [9:0]       lat_x [2];
  logic [9:0]       lat_y [2];
  logic [1:0]       row_valid;
  logic [7:0]       line_buf [2][SPR_W];
  logic [COL_W:0]   col_cnt;
  logic             cur;
  logic [1:0]       hit;
  logic [ROW_W-1:0] row [2];
  logic [COL_W-1:0] wr_col;
  logic [7:0]       pix [2];
  logic [1:0]       opaque;

  // One pulse per line even though DrawX dwells on the blank column for two clocks.
  assign trig   = blank_q & ~blank_prev;
  assign cur    = (state == FETCH1);
  assign wr_col = COL_W'(col_cnt - 1'b1);

  // 11-bit compares so a sprite near the bottom never wraps onto the top lines.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hit[s] = ({1'b0, next_y} >= {1'b0, lat_y[s]}) &&
               ({1'b0, next_y} <  {1'b0, lat_y[s]} + 11'(SPR_H));
      row[s] = ROW_W'(next_y - lat_y[s]);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trig) state_next = FETCH0;
      FETCH0:  if (!hit[0] || col_cnt == LAST_COL) state_next = FETCH1;
      FETCH1:  if (!hit[1] || col_cnt == LAST_COL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_busy = (state != IDLE);
    rom_addr   = '0;
    if (fetch_busy && hit[cur] && col_cnt != LAST_COL)
      rom_addr = (cur ? SPR_WORDS : '0) + ROM_AW'(row[cur]) * ROM_AW'(SPR_W) + ROM_AW'(col_cnt);
  end

  // NOTE: the line buffers are reset on purpose so a freshly reset display shows nothing;
  // sequential state uses non-blocking assignments throughout.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blank_q    <= 1'b0;
      blank_prev <= 1'b0;
      overrun    <= 1'b0;
      next_y     <= '0;
      row_valid  <= '0;
      col_cnt    <= '0;
      for (int s = 0; s < 2; s++) begin
        lat_x[s] <= '0;
        lat_y[s] <= '0;
        for (int c = 0; c < SPR_W; c++) line_buf[s][c] <= '0;
      end
    end else begin
      blank_q    <= (DrawX == BLANK_X);
      blank_prev <= blank_q;
      if (trig && state != IDLE) overrun <= 1'b1;
      if (trig && state == IDLE) begin
        next_y   <= (DrawY == LAST_Y) ? '0 : DrawY + 10'd1;
        lat_x[0] <= fb_x;
        lat_y[0] <= fb_y;
        lat_x[1] <= ig_x;
        lat_y[1] <= ig_y;
      end
      if (fetch_busy) begin
        col_cnt <= (state_next != state) ? '0 : col_cnt + 1'b1;
        // Hide the old row as soon as this sprite's fetch begins.
        if (col_cnt == '0) row_valid[cur] <= 1'b0;
        if (hit[cur] && col_cnt != '0) line_buf[cur][wr_col] <= rom_data;
        if (hit[cur] && col_cnt == LAST_COL) row_valid[cur] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pix[s]    = line_buf[s][COL_W'(DrawX - lat_x[s])];
      opaque[s] = row_valid[s] && (DrawX >= lat_x[s]) &&
                  ({1'b0, DrawX} < {1'b0, lat_x[s]} + 11'(SPR_W)) &&
                  (DrawX < BLANK_X) && (pix[s] != 8'd0);
    end
    is_fireboy   = 1'b0;
    fireboy_data = '0;
    if (opaque[0]) begin
      is_fireboy   = 1'b1;
      fireboy_data = pix[0];
    end else if (opaque[1]) begin
      is_fireboy   = 1'b1;
      fireboy_data = pix[1];
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Scoreboard bench for sprite_row_fetcher: expected bus cycles and pixels are queued
// from a small reference model when stimulus is driven and compared as the DUT responds.
module tb_sprite_row_fetcher;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY, fb_x, fb_y, ig_x, ig_y;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        is_fireboy;
  logic [7:0]  fireboy_data;
  logic        fetch_busy;
  logic        overrun;

  always #5 Clk = ~Clk;

  sprite_row_fetcher dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .fb_x(fb_x), .fb_y(fb_y), .ig_x(ig_x), .ig_y(ig_y),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .is_fireboy(is_fireboy), .fireboy_data(fireboy_data),
    .fetch_busy(fetch_busy), .overrun(overrun)
  );

  logic [7:0] rom [2048];
  always @(posedge Clk) rom_data <= rom[rom_addr];

  typedef enum {K_BUS, K_PIX, K_OVR} kind_t;
  typedef struct {
    kind_t       kind;
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   m_valid [2];
  int   m_x [2];
  int   m_row [2];

  // Fireboy: r+c+1 with column 12 transparent; icegirl: r+c+100 with column 2 = 7.
  function automatic logic [7:0] rom_val(input int s, input int r, input int c);
    if (s == 0) return (c == 12) ? 8'd0 : 8'(r + c + 1);
    return (c == 2) ? 8'd7 : 8'(r + c + 100);
  endfunction

  function automatic logic [15:0] exp_pix(input int x);
    for (int s = 0; s < 2; s++)
      if (m_valid[s] && x >= m_x[s] && x < m_x[s] + 32 && x < 640 &&
          rom_val(s, m_row[s], x - m_x[s]) != 8'd0)
        return {7'd0, 1'b1, rom_val(s, m_row[s], x - m_x[s])};
    return 16'd0;
  endfunction

  function automatic void push(input kind_t k, input string tag, input logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.tag  = tag;
    e.exp  = v;
    sb.push_back(e);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t        e;
    logic [15:0] got;
    e = sb.pop_front();
    case (e.kind)
      K_BUS:   got = {4'd0, fetch_busy, rom_addr};
      K_PIX:   got = {7'd0, is_fireboy, fireboy_data};
      default: got = {15'd0, overrun};
    endcase
    check(e.tag, got, e.exp);
  endtask

  // Called just after a negedge; returns just after a later negedge.
  task automatic pix_check(input int x);
    DrawX = 10'(x);
    push(K_PIX, $sformatf("pix_x%0d", x), exp_pix(x));
    @(negedge Clk);
    pop_compare();
  endtask

  task automatic ovr_check(input logic v, input string tag);
    push(K_OVR, tag, {15'd0, v});
    @(negedge Clk);
    pop_compare();
  endtask

  // Drives one hblank trigger on line y and checks every fetch cycle on the ROM bus.
  // retrig >= 0 forces a second trigger (and moves fb_y) mid-fetch; abort_at >= 0 resets.
  task automatic run_fetch(input int y, input int retrig, input int abort_at);
    int ny, n;
    int px [2];
    int py [2];
    bit h [2];
    ny = (y == 524) ? 0 : y + 1;
    px[0] = fb_x; py[0] = fb_y; px[1] = ig_x; py[1] = ig_y;
    DrawY = 10'(y);
    DrawX = 10'd640;
    push(K_BUS, "idle_pre", 16'd0);
    for (int s = 0; s < 2; s++) begin
      h[s] = (ny >= py[s]) && (ny < py[s] + 32);
      if (h[s]) begin
        for (int k = 0; k <= 32; k++)
          push(K_BUS, $sformatf("y%0d_s%0d_c%0d", y, s, k),
               (k < 32) ? 16'(32'h800 | (s * 1024 + (ny - py[s]) * 32 + k)) : 16'h800);
      end else begin
        push(K_BUS, $sformatf("y%0d_s%0d_miss", y, s), 16'h800);
      end
    end
    push(K_BUS, "idle_post", 16'd0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      pop_compare();
      if (i == 1) DrawX = 10'd641;
      if (i == retrig) DrawX = 10'd640;
      if (i == retrig + 2) DrawX = 10'd641;
      if (i == 5 && retrig >= 0) fb_y = fb_y + 10'd7;
      if (i == abort_at) begin
        Reset = 1'b1;
        DrawX = 10'd641;
        sb.delete();
        m_valid = '{1'b0, 1'b0};
        return;
      end
    end
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = h[s];
      m_x[s]     = px[s];
      m_row[s]   = ny - py[s];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = rom_val(a / 1024, (a % 1024) / 32, a % 32);
    m_valid = '{1'b0, 1'b0};
    m_x     = '{0, 0};
    m_row   = '{0, 0};
    Reset = 1'b1;
    DrawX = 10'd100; DrawY = '0;
    fb_x = '0; fb_y = '0; ig_x = '0; ig_y = '0;
    repeat (2) @(negedge Clk);

    push(K_BUS, "reset_bus", 16'd0);
    push(K_PIX, "reset_pix", 16'd0);
    push(K_OVR, "reset_ovr", 16'd0);
    #1;
    repeat (3) pop_compare();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Single sprite, row 0 of fireboy.
    fb_x = 10'd100; fb_y = 10'd50; ig_x = 10'd300; ig_y = 10'd300;
    run_fetch(49, -1, -1);
    pix_check(100); pix_check(131); pix_check(132); pix_check(112); pix_check(99);

    // Second trigger mid-fetch plus a moved sprite: overrun sticks, fetch unaffected.
    fb_x = 10'd100; fb_y = 10'd50; ig_x = 10'd110; ig_y = 10'd50;
    ovr_check(1'b0, "ovr_before");
    run_fetch(49, 19, -1);
    ovr_check(1'b1, "ovr_set");
    pix_check(100); pix_check(112);

    // Both sprites miss: two busy cycles, nothing drawn.
    run_fetch(200, -1, -1);
    ovr_check(1'b1, "ovr_sticky");
    pix_check(100); pix_check(112);

    // Bottom of frame: icegirl row 24 on the last line, no wrap onto line 0.
    fb_x = 10'd300; fb_y = 10'd0; ig_x = 10'd200; ig_y = 10'd500;
    run_fetch(523, -1, -1);
    pix_check(200); pix_check(202); pix_check(231); pix_check(232);
    run_fetch(524, -1, -1);
    pix_check(300); pix_check(200);

    // Sprite crossing the right edge of active video.
    fb_x = 10'd620; fb_y = 10'd10; ig_x = 10'd0; ig_y = 10'd400;
    run_fetch(9, -1, -1);
    pix_check(620); pix_check(639); pix_check(645); pix_check(651);

    // Overlap: fireboy wins unless its pixel is transparent.
    fb_x = 10'd100; fb_y = 10'd50; ig_x = 10'd110; ig_y = 10'd50;
    run_fetch(49, -1, -1);
    pix_check(112); pix_check(111); pix_check(141); pix_check(142);
    run_fetch(50, -1, -1);
    pix_check(100); pix_check(112);

    // Reset in the middle of fireboy's fetch at column 10.
    run_fetch(49, -1, 11);
    DrawX = 10'd112;
    push(K_BUS, "midrst_bus", 16'd0);
    push(K_PIX, "midrst_pix", 16'd0);
    push(K_OVR, "midrst_ovr", 16'd0);
    #1;
    repeat (3) pop_compare();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) begin
      push(K_BUS, "post_rst_idle", 16'd0);
      @(negedge Clk);
      pop_compare();
    end
    pix_check(112);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
